// File: rtl/mult_pkg.sv
// Shared definitions for the signed shift-add multiplier datapath.
//   DEFAULT_WIDTH : default operand width of A, B and S
//   cmd_e         : the single command executed in a cycle, after priority
//                   resolution of the raw strobes
//   strobe_count  : number of raw strobes asserted in a cycle (for CmdErr)
package mult_pkg;

    localparam int DEFAULT_WIDTH = 8;

    // Listed lowest to highest priority.
    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_SHIFT = 3'd1,
        CMD_ADD   = 3'd2,
        CMD_SUB   = 3'd3,
        CMD_CLRXA = 3'd4,
        CMD_CLRLD = 3'd5
    } cmd_e;

    // Population count of the five command strobes.
    function automatic logic [2:0] strobe_count(input logic [4:0] strobes);
        logic [2:0] cnt;
        cnt = 3'd0;
        for (int i = 0; i < 5; i++) begin
            cnt = cnt + {2'b00, strobes[i]};
        end
        return cnt;
    endfunction

endpackage

// File: rtl/adder_sub9.sv
// (WIDTH+1)-bit combinational add/subtract used for the partial product.
//   a   : current A register (signed, WIDTH bits)
//   s   : multiplicand from the switches (signed, WIDTH bits)
//   sub : 1 selects a - s, 0 selects a + s
//   sum : sign-extended result, WIDTH+1 bits; bit WIDTH is the new X
// Both operands are sign-extended by one bit so that the top bit is the true
// sign of the result rather than a carry; overflow beyond that is dropped.
// This also makes a - (-2^(WIDTH-1)) come out as the correct positive value.
module adder_sub9 #(
    parameter int WIDTH = mult_pkg::DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] s,
    input  logic             sub,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] s_ext;
    logic [WIDTH:0] s_opnd;

    assign a_ext  = {a[WIDTH-1], a};
    assign s_ext  = {s[WIDTH-1], s};
    // Two's complement subtract: invert and inject the +1 as carry-in.
    assign s_opnd = sub ? ~s_ext : s_ext;
    assign sum    = a_ext + s_opnd + {{WIDTH{1'b0}}, sub};

endmodule

// File: rtl/multiplier_datapath.sv
// Register/arithmetic datapath of the signed shift-add multiplier.
// Inputs:
//   Clk, Reset (async, active-low)
//   S       : multiplicand for Add/Sub, multiplier value for Clr_Ld
//   Shift, Add, Sub, Clr_Ld, Clr_XA : command strobes from the control unit
// Outputs:
//   M        : current multiplier LSB (B[0]) back to the control unit
//   X, Aval, Bval : sign-extension bit, upper and lower product registers
//   ShiftCnt : shifts executed since the last clear, saturating at WIDTH
//   Done     : one-cycle pulse after the WIDTH-th shift
//   CmdErr   : sticky flag, two or more strobes seen in one cycle
module multiplier_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                       Clk,
    input  logic                       Reset,
    input  logic [WIDTH-1:0]           S,
    input  logic                       Shift,
    input  logic                       Add,
    input  logic                       Sub,
    input  logic                       Clr_Ld,
    input  logic                       Clr_XA,
    output logic                       M,
    output logic                       X,
    output logic [WIDTH-1:0]           Aval,
    output logic [WIDTH-1:0]           Bval,
    output logic [$clog2(WIDTH):0]     ShiftCnt,
    output logic                       Done,
    output logic                       CmdErr
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

    logic             x_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [CW-1:0]    cnt_q;
    logic             done_q;
    logic             err_q;

    cmd_e             cmd;
    logic             multi;
    logic [WIDTH:0]   sum;

    // Priority resolution: Clr_Ld > Clr_XA > Sub > Add > Shift.
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        cmd = CMD_NONE;
        if (Clr_Ld)      cmd = CMD_CLRLD;
        else if (Clr_XA) cmd = CMD_CLRXA;
        else if (Sub)    cmd = CMD_SUB;
        else if (Add)    cmd = CMD_ADD;
        else if (Shift)  cmd = CMD_SHIFT;
    end

    // Counted on the raw strobes, so an Add/Sub with M=0 still counts.
    assign multi = strobe_count({Clr_Ld, Clr_XA, Sub, Add, Shift}) > 3'd1;

    adder_sub9 #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a   (a_q),
        .s   (S),
        .sub (cmd == CMD_SUB),
        .sum (sum)
    );

    // NOTE: state is updated with non-blocking assignments only, so every
    // right-hand side sees the pre-edge register values (the shift relies on
    // reading old X/A/B while writing new ones).
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            x_q    <= 1'b0;
            a_q    <= '0;
            b_q    <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;

            unique case (cmd)
                CMD_CLRLD: begin
                    x_q   <= 1'b0;
                    a_q   <= '0;
                    b_q   <= S;
                    cnt_q <= '0;
                end
                CMD_CLRXA: begin
                    x_q   <= 1'b0;
                    a_q   <= '0;
                    cnt_q <= '0;
                end
                CMD_ADD, CMD_SUB: begin
                    if (b_q[0]) begin
                        a_q <= sum[WIDTH-1:0];
                        x_q <= sum[WIDTH];
                    end
                end
                CMD_SHIFT: begin
                    a_q <= {x_q, a_q[WIDTH-1:1]};
                    b_q <= {a_q[0], b_q[WIDTH-1:1]};
                    // Saturate so trailing shifts never re-pulse Done.
                    if (cnt_q != CNT_MAX) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                    done_q <= (cnt_q == CNT_LAST);
                end
                default: ;
            endcase

            // Setting wins over the Clr_Ld clear when both happen together.
            if (multi) begin
                err_q <= 1'b1;
            end else if (cmd == CMD_CLRLD) begin
                err_q <= 1'b0;
            end
        end
    end

    assign M        = b_q[0];
    assign X        = x_q;
    assign Aval     = a_q;
    assign Bval     = b_q;
    assign ShiftCnt = cnt_q;
    assign Done     = done_q;
    assign CmdErr   = err_q;

endmodule

// File: tb/tb_multiplier_datapath.sv
// Self-checking bench for multiplier_datapath (WIDTH = 8).
module tb_multiplier_datapath;

    localparam int W = 8;

    localparam logic [4:0] ST_NONE  = 5'b00000;
    localparam logic [4:0] ST_SHIFT = 5'b00001;
    localparam logic [4:0] ST_ADD   = 5'b00010;
    localparam logic [4:0] ST_SUB   = 5'b00100;
    localparam logic [4:0] ST_CLRXA = 5'b01000;
    localparam logic [4:0] ST_CLRLD = 5'b10000;

    typedef struct {
        logic [15:0] prod;
        logic        x;
        string       name;
    } exp_t;

    logic         Clk;
    logic         Reset;
    logic [W-1:0] S;
    logic         Shift, Add, Sub, Clr_Ld, Clr_XA;
    logic         M, X, Done, CmdErr;
    logic [W-1:0] Aval, Bval;
    logic [3:0]   ShiftCnt;

    int   checks;
    int   errors;
    int   done_count;
    exp_t sb[$];

    multiplier_datapath #(.WIDTH(W)) dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .S        (S),
        .Shift    (Shift),
        .Add      (Add),
        .Sub      (Sub),
        .Clr_Ld   (Clr_Ld),
        .Clr_XA   (Clr_XA),
        .M        (M),
        .X        (X),
        .Aval     (Aval),
        .Bval     (Bval),
        .ShiftCnt (ShiftCnt),
        .Done     (Done),
        .CmdErr   (CmdErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Drive strobes, take one rising edge, sample 1 ns later, release strobes.
    task automatic step(input logic [4:0] str);
        {Clr_Ld, Clr_XA, Sub, Add, Shift} = str;
        @(posedge Clk);
        #1;
        {Clr_Ld, Clr_XA, Sub, Add, Shift} = ST_NONE;
        if (Done === 1'b1) done_count++;
    endtask

    // Full WIDTH-step signed multiply; the expected product is pushed on entry
    // and popped once the sequence has completed.
    task automatic run_mult(input logic [7:0] mcand, input logic [7:0] mplier,
                            input bit load, input string name);
        exp_t        e;
        logic signed [15:0] p;
        logic        done_last;
        p = $signed(mcand) * $signed(mplier);
        e.prod = p;
        e.x    = p[15];
        e.name = name;
        sb.push_back(e);

        if (load) begin
            S = mplier;
            step(ST_CLRLD);
        end
        S = mcand;
        done_count = 0;
        done_last  = 1'b0;
        for (int i = 0; i < W; i++) begin
            step((i < W - 1) ? ST_ADD : ST_SUB);
            step(ST_SHIFT);
            if (i == W - 1) done_last = Done;
        end
        step(ST_NONE);

        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            checks++;
            if ({Aval, Bval} !== e.prod) begin
                errors++;
                $display("FAIL %s product got %h exp %h", e.name, {Aval, Bval}, e.prod);
            end
            checks++;
            if (X !== e.x) begin
                errors++;
                $display("FAIL %s X got %b exp %b", e.name, X, e.x);
            end
        end
        checks++;
        if (ShiftCnt !== 4'd8) begin
            errors++;
            $display("FAIL %s shiftcnt got %0d exp 8", name, ShiftCnt);
        end
        checks++;
        if (done_last !== 1'b1 || done_count != 1) begin
            errors++;
            $display("FAIL %s done last=%b count=%0d exp 1/1", name, done_last, done_count);
        end
        checks++;
        if (Done !== 1'b0) begin
            errors++;
            $display("FAIL %s done not cleared got %b", name, Done);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        S     = 8'hFF;
        for (int i = 0; i < 4; i++) begin
            Shift = i[0];
            @(posedge Clk);
            #1;
            checks++;
            if ({X, Aval, Bval, ShiftCnt, Done, CmdErr} !== '0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d got X=%b A=%h B=%h cnt=%0d done=%b err=%b exp all 0",
                         i, X, Aval, Bval, ShiftCnt, Done, CmdErr);
            end
        end
        Shift = 1'b0;
        Reset = 1'b1;
        step(ST_NONE);
    endtask

    task automatic test_basic();
        run_mult(8'h07, 8'hFD, 1'b1, "mul_7x-3");
    endtask

    // B still holds 0xEB from the previous product.
    task automatic test_clr_xa();
        step(ST_CLRXA);
        checks++;
        if ({X, Aval, Bval, ShiftCnt} !== {1'b0, 8'h00, 8'hEB, 4'd0}) begin
            errors++;
            $display("FAIL clr_xa got X=%b A=%h B=%h cnt=%0d exp 0/00/EB/0", X, Aval, Bval, ShiftCnt);
        end
        run_mult(8'h02, 8'hEB, 1'b0, "mul_rerun");
    endtask

    task automatic test_min_neg();
        run_mult(8'h80, 8'h80, 1'b1, "mul_min_neg");
        // Saturated counter: registers still shift, no Done, count stays 8.
        done_count = 0;
        step(ST_SHIFT);
        step(ST_NONE);
        checks++;
        if ({Aval, Bval} !== 16'h2000 || ShiftCnt !== 4'd8 || done_count != 0) begin
            errors++;
            $display("FAIL saturate got AB=%h cnt=%0d dones=%0d exp 2000/8/0", {Aval, Bval}, ShiftCnt, done_count);
        end
    endtask

    task automatic test_cmd_err();
        // M=0: Add leaves A untouched.
        S = 8'h02;
        step(ST_CLRLD);
        S = 8'h05;
        step(ST_ADD);
        checks++;
        if ({X, Aval, Bval, CmdErr} !== {1'b0, 8'h00, 8'h02, 1'b0}) begin
            errors++;
            $display("FAIL add_m0 got X=%b A=%h B=%h err=%b exp 0/00/02/0", X, Aval, Bval, CmdErr);
        end
        // M=1 with Add+Shift: only the add runs, error latches.
        S = 8'h01;
        step(ST_CLRLD);
        S = 8'h05;
        step(ST_ADD | ST_SHIFT);
        checks++;
        if ({X, Aval, Bval, ShiftCnt, CmdErr} !== {1'b0, 8'h05, 8'h01, 4'd0, 1'b1}) begin
            errors++;
            $display("FAIL cmd_err_add got X=%b A=%h B=%h cnt=%0d err=%b exp 0/05/01/0/1",
                     X, Aval, Bval, ShiftCnt, CmdErr);
        end
        step(ST_SHIFT);
        step(ST_CLRXA);
        step(ST_NONE);
        checks++;
        if (CmdErr !== 1'b1) begin
            errors++;
            $display("FAIL cmd_err_sticky got %b exp 1", CmdErr);
        end
        step(ST_CLRLD);
        checks++;
        if (CmdErr !== 1'b0) begin
            errors++;
            $display("FAIL cmd_err_clear got %b exp 0", CmdErr);
        end
    endtask

    task automatic test_reset_mid();
        S = 8'h05;
        step(ST_CLRLD);
        S = 8'h03;
        done_count = 0;
        for (int i = 0; i < 4; i++) begin
            step(ST_ADD);
            step(ST_SHIFT);
        end
        #2;
        Reset = 1'b0;
        #1;
        checks++;
        if ({X, Aval, Bval, ShiftCnt, Done} !== '0) begin
            errors++;
            $display("FAIL reset_mid got X=%b A=%h B=%h cnt=%0d done=%b exp all 0",
                     X, Aval, Bval, ShiftCnt, Done);
        end
        for (int i = 0; i < 2; i++) begin
            Shift = 1'b1;
            @(posedge Clk);
            #1;
            Shift = 1'b0;
            if (Done === 1'b1) done_count++;
        end
        checks++;
        if ({Aval, Bval, ShiftCnt} !== '0 || done_count != 0) begin
            errors++;
            $display("FAIL reset_mid_hold got AB=%h cnt=%0d dones=%0d exp 0/0/0", {Aval, Bval}, ShiftCnt, done_count);
        end
        Reset = 1'b1;
        step(ST_NONE);
        run_mult(8'h03, 8'h05, 1'b1, "mul_after_reset");
    endtask

    initial begin
        checks = 0;
        errors = 0;
        done_count = 0;
        Reset  = 1'b0;
        S      = '0;
        {Clr_Ld, Clr_XA, Sub, Add, Shift} = ST_NONE;

        test_reset();
        test_basic();
        test_clr_xa();
        test_min_neg();
        test_cmd_err();
        test_reset_mid();

        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d exp 0", sb.size());
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time guard so the run cannot hang.
    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
